// File: rtl/rational_crossing_sink_channel.sv
// Receive end of a single-channel rational clock crossing.
// Accepts the two-slot payload bundle published by the source (bits0 for
// even item indices, bits1 for odd ones, plus a mod-4 publish counter) and
// presents the items as a valid/ready stream in the local clock domain. The
// consume counter goes back to the source for flow control. A protocol error
// (three items apparently pending) is flagged and held until reset.
module rational_crossing_sink_channel #(
    parameter int W       = 32,
    parameter bit REG_OUT = 1'b1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] enq_bits0,
    input  logic [W-1:0] enq_bits1,
    input  logic [1:0]   enq_source,
    output logic [1:0]   enq_sink,
    output logic         deq_valid,
    input  logic         deq_ready,
    output logic [W-1:0] deq_bits,
    output logic [1:0]   occupancy,
    output logic         proto_err
);

    logic [1:0]   snk_count_q;
    logic [1:0]   snk_count_d;
    logic         err_q;
    logic         err_d;
    logic         avail;
    logic         consume;
    logic [W-1:0] slot_bits;

    // Items pending in the crossing slots; mod-4 arithmetic handles the wrap.
    assign occupancy = enq_source - snk_count_q;
    assign avail     = (occupancy != 2'd0);
    assign slot_bits = snk_count_q[0] ? enq_bits1 : enq_bits0;

    // The source only ever has two slots, so a distance of 3 is illegal.
    assign err_d       = err_q | (occupancy == 2'd3);
    assign snk_count_d = consume ? snk_count_q + 2'd1 : snk_count_q;

    // The returned counter is the register itself, never a path from inputs.
    assign enq_sink  = snk_count_q;
    assign proto_err = err_q;

    // Consume counter and sticky error flag.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snk_count_q <= 2'd0;
            err_q       <= 1'b0;
        end else begin
            snk_count_q <= snk_count_d;
            err_q       <= err_d;
        end
    end

    generate
        if (REG_OUT) begin : g_reg_out
            logic         out_valid_q;
            logic         out_valid_d;
            logic [W-1:0] out_bits_q;
            logic [W-1:0] out_bits_d;
            logic         load;

            // Refill whenever the pipe register is empty or being drained this
            // cycle, giving one item per cycle with back-to-back handshakes.
            assign load = avail && (!out_valid_q || deq_ready);

            // Next-state of the one-entry output register.
            // NOTE: defaults first so every path assigns every signal; a missing
            // branch would otherwise infer a latch.
            always_comb begin
                out_valid_d = out_valid_q;
                out_bits_d  = out_bits_q;
                if (load) begin
                    out_valid_d = 1'b1;
                    out_bits_d  = slot_bits;
                end else if (deq_ready && out_valid_q) begin
                    out_valid_d = 1'b0;
                end
            end

            // Output register; the data register is reset too so deq_bits is
            // a known zero after reset rather than stale crossing contents.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    out_valid_q <= 1'b0;
                    out_bits_q  <= '0;
                end else begin
                    out_valid_q <= out_valid_d;
                    out_bits_q  <= out_bits_d;
                end
            end

            assign consume   = load;
            assign deq_valid = out_valid_q;
            assign deq_bits  = out_bits_q;
        end else begin : g_comb_out
            assign consume   = avail && deq_ready;
            assign deq_valid = avail;
            assign deq_bits  = slot_bits;
        end
    endgenerate

endmodule
